// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer: opcodes,
// IR field positions, sequencer states and instruction classes.
package cpu_ctrl_pkg;

  localparam int unsigned OPW = 5;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01001;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RR, C_IMM, C_UNARY, C_MULDIV, C_NOP, C_HALT, C_ILL
  } iclass_t;

  function automatic iclass_t decode_class(input logic [OPW-1:0] op);
    iclass_t c;
    c = C_ILL;
    if (op <= OP_ROL) begin
      c = C_RR;
    end else if (op >= OP_ADDI && op <= OP_ORI) begin
      c = C_IMM;
    end else begin
      case (op)
        OP_MUL, OP_DIV: c = C_MULDIV;
        OP_NEG, OP_NOT: c = C_UNARY;
        OP_NOP:         c = C_NOP;
        OP_HALT:        c = C_HALT;
        default:        c = C_ILL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Binary-to-one-hot register select decoder with enable; all zeros when disabled.
module reg_select_decoder #(
  parameter int unsigned NOUT = 16,
  parameter int unsigned SELW = 4
) (
  input  logic            en,
  input  logic [SELW-1:0] sel,
  output logic [NOUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, decode IR, execute T3-T6, with HALT
// and asynchronous active-low clear. All outputs are Moore-decoded.
module control_sequencer #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      IR,
  input  logic             Stop,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             HIin,
  output logic             LOin,
  output logic             Zhighin,
  output logic             Zlowin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             MARin,
  output logic             HIout,
  output logic             LOout,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic             PCout,
  output logic             MDRout,
  output logic             Cout,
  output logic             IncPC,
  output logic             Read,
  output logic [OPW-1:0]   ALUopcode,
  output logic             Run,
  output logic             ill_op
);
  import cpu_ctrl_pkg::*;

  state_t     state, state_nx, ret_state;
  iclass_t    cls;
  logic [OPW-1:0] op;
  logic [3:0] ra, rb, rc;
  logic       rin_en, rout_en;
  logic [3:0] rin_sel, rout_sel;

  assign op  = IR[OP_MSB:OP_LSB];
  assign ra  = IR[RA_MSB:RA_LSB];
  assign rb  = IR[RB_MSB:RB_LSB];
  assign rc  = IR[RC_MSB:RC_LSB];
  assign cls = decode_class(op);

  // Every instruction's final execute step returns here; Stop only matters then.
  assign ret_state = Stop ? S_HALT : S_T0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_RST;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    HIin = 1'b0; LOin = 1'b0; Zhighin = 1'b0; Zlowin = 1'b0;
    PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; MARin = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    IncPC = 1'b0; Read = 1'b0; ill_op = 1'b0;
    ALUopcode = '0;
    Run       = (state != S_RST) && (state != S_HALT);
    rin_en    = 1'b0;
    rin_sel   = ra;
    rout_en   = 1'b0;
    rout_sel  = rb;
    case (state)
      S_RST: state_nx = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_nx = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        case (cls)
          C_RR, C_IMM: begin
            rout_en = 1'b1; Yin = 1'b1; state_nx = S_T4;
          end
          C_UNARY: begin
            rout_en = 1'b1; ALUopcode = op; Zhighin = 1'b1; Zlowin = 1'b1;
            state_nx = S_T4;
          end
          C_MULDIV: begin
            rout_en = 1'b1; rout_sel = ra; Yin = 1'b1; state_nx = S_T4;
          end
          C_HALT:  state_nx = S_HALT;
          C_ILL: begin
            ill_op = 1'b1; state_nx = ret_state;
          end
          default: state_nx = ret_state;
        endcase
      end
      S_T4: begin
        case (cls)
          C_RR: begin
            rout_en = 1'b1; rout_sel = rc;
            ALUopcode = op; Zhighin = 1'b1; Zlowin = 1'b1; state_nx = S_T5;
          end
          C_IMM: begin
            Cout = 1'b1; ALUopcode = op; Zhighin = 1'b1; Zlowin = 1'b1;
            state_nx = S_T5;
          end
          C_UNARY: begin
            Zlowout = 1'b1; rin_en = 1'b1; state_nx = ret_state;
          end
          C_MULDIV: begin
            rout_en = 1'b1; ALUopcode = op; Zhighin = 1'b1; Zlowin = 1'b1;
            state_nx = S_T5;
          end
          default: state_nx = S_T0;
        endcase
      end
      S_T5: begin
        case (cls)
          C_RR, C_IMM: begin
            Zlowout = 1'b1; rin_en = 1'b1; state_nx = ret_state;
          end
          C_MULDIV: begin
            Zlowout = 1'b1; LOin = 1'b1; state_nx = S_T6;
          end
          default: state_nx = S_T0;
        endcase
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; state_nx = ret_state;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  reg_select_decoder #(.NOUT(NREGS), .SELW(4)) u_rin_dec (
    .en(rin_en), .sel(rin_sel), .onehot(Rin)
  );

  reg_select_decoder #(.NOUT(NREGS), .SELW(4)) u_rout_dec (
    .en(rout_en), .sel(rout_sel), .onehot(Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle table of expected outputs
// plus hand sequences for clear-abort and halt hold.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        Stop;
  logic [15:0] Rin, Rout;
  logic HIin, LOin, Zhighin, Zlowin, PCin, MDRin, IRin, Yin, MARin;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout;
  logic IncPC, Read, Run, ill_op;
  logic [4:0]  ALUopcode;

  control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
    .Rin(Rin), .Rout(Rout),
    .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .MARin(MARin),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .Cout(Cout),
    .IncPC(IncPC), .Read(Read), .ALUopcode(ALUopcode),
    .Run(Run), .ill_op(ill_op)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] F_HIin     = 20'h80000;
  localparam logic [19:0] F_LOin     = 20'h40000;
  localparam logic [19:0] F_Zhighin  = 20'h20000;
  localparam logic [19:0] F_Zlowin   = 20'h10000;
  localparam logic [19:0] F_PCin     = 20'h08000;
  localparam logic [19:0] F_MDRin    = 20'h04000;
  localparam logic [19:0] F_IRin     = 20'h02000;
  localparam logic [19:0] F_Yin      = 20'h01000;
  localparam logic [19:0] F_MARin    = 20'h00800;
  localparam logic [19:0] F_HIout    = 20'h00400;
  localparam logic [19:0] F_LOout    = 20'h00200;
  localparam logic [19:0] F_Zhighout = 20'h00100;
  localparam logic [19:0] F_Zlowout  = 20'h00080;
  localparam logic [19:0] F_PCout    = 20'h00040;
  localparam logic [19:0] F_MDRout   = 20'h00020;
  localparam logic [19:0] F_Cout     = 20'h00010;
  localparam logic [19:0] F_IncPC    = 20'h00008;
  localparam logic [19:0] F_Read     = 20'h00004;
  localparam logic [19:0] F_Run      = 20'h00002;
  localparam logic [19:0] F_ill      = 20'h00001;

  localparam logic [19:0] F_T0  = F_PCout | F_MARin | F_IncPC | F_Zlowin | F_Run;
  localparam logic [19:0] F_T1  = F_Zlowout | F_PCin | F_Read | F_MDRin | F_Run;
  localparam logic [19:0] F_T2  = F_MDRout | F_IRin | F_Run;
  localparam logic [19:0] F_ALU = F_Zhighin | F_Zlowin | F_Run;

  localparam logic [31:0] IR_NOT  = 32'h9008_0000;
  localparam logic [31:0] IR_ADD  = 32'h0189_0000;
  localparam logic [31:0] IR_ADDI = 32'h4B38_0000;
  localparam logic [31:0] IR_MUL  = 32'h7A28_0000;
  localparam logic [31:0] IR_DIV  = 32'h8118_0000;
  localparam logic [31:0] IR_NEG  = 32'h8FF0_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_ILL1 = 32'hF800_0000;
  localparam logic [31:0] IR_ILL2 = 32'h6000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        stop;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [19:0] f;
    logic [4:0]  alu;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [56:0] act;
  assign act = {Rin, Rout, HIin, LOin, Zhighin, Zlowin, PCin, MDRin, IRin, Yin,
                MARin, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout,
                IncPC, Read, Run, ill_op, ALUopcode};

  function automatic logic [56:0] pk(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic [19:0] f, input logic [4:0] alu);
    return {rin, rout, f, alu};
  endfunction

  task automatic check(input string name, input logic [56:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic row(input string name, input logic [31:0] ir, input logic stop,
                     input logic [15:0] rin, input logic [15:0] rout,
                     input logic [19:0] f, input logic [4:0] alu);
    vec_t v;
    v.name = name; v.ir = ir; v.stop = stop;
    v.rin = rin; v.rout = rout; v.f = f; v.alu = alu;
    tbl.push_back(v);
  endtask

  task automatic fetch_rows(input string nm, input logic [31:0] ir, input logic stop);
    row({nm, " T0"}, ir, stop, 16'h0, 16'h0, F_T0, 5'd0);
    row({nm, " T1"}, ir, stop, 16'h0, 16'h0, F_T1, 5'd0);
    row({nm, " T2"}, ir, stop, 16'h0, 16'h0, F_T2, 5'd0);
  endtask

  task automatic reset_to_t0(input logic [31:0] ir);
    clr = 1'b0; Stop = 1'b0; IR = ir;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; Stop = 1'b0; IR = IR_NOT;

    fetch_rows("not", IR_NOT, 1'b0);
    row("not T3", IR_NOT, 1'b0, 16'h0000, 16'h0002, F_ALU, 5'b10010);
    row("not T4", IR_NOT, 1'b0, 16'h0001, 16'h0000, F_Zlowout | F_Run, 5'd0);

    fetch_rows("add", IR_ADD, 1'b0);
    row("add T3", IR_ADD, 1'b0, 16'h0000, 16'h0002, F_Yin | F_Run, 5'd0);
    row("add T4", IR_ADD, 1'b0, 16'h0000, 16'h0004, F_ALU, 5'd0);
    row("add T5", IR_ADD, 1'b0, 16'h0008, 16'h0000, F_Zlowout | F_Run, 5'd0);

    fetch_rows("addi stop-early", IR_ADDI, 1'b1);
    row("addi T3", IR_ADDI, 1'b1, 16'h0000, 16'h0080, F_Yin | F_Run, 5'd0);
    row("addi T4", IR_ADDI, 1'b1, 16'h0000, 16'h0000, F_ALU | F_Cout, 5'b01001);
    row("addi T5", IR_ADDI, 1'b0, 16'h0040, 16'h0000, F_Zlowout | F_Run, 5'd0);

    fetch_rows("mul", IR_MUL, 1'b0);
    row("mul T3", IR_MUL, 1'b0, 16'h0000, 16'h0010, F_Yin | F_Run, 5'd0);
    row("mul T4", IR_MUL, 1'b0, 16'h0000, 16'h0020, F_ALU, 5'b01111);
    row("mul T5", IR_MUL, 1'b0, 16'h0000, 16'h0000, F_Zlowout | F_LOin | F_Run, 5'd0);
    row("mul T6", IR_MUL, 1'b0, 16'h0000, 16'h0000, F_Zhighout | F_HIin | F_Run, 5'd0);

    fetch_rows("div", IR_DIV, 1'b0);
    row("div T3", IR_DIV, 1'b0, 16'h0000, 16'h0004, F_Yin | F_Run, 5'd0);
    row("div T4", IR_DIV, 1'b0, 16'h0000, 16'h0008, F_ALU, 5'b10000);
    row("div T5", IR_DIV, 1'b0, 16'h0000, 16'h0000, F_Zlowout | F_LOin | F_Run, 5'd0);
    row("div T6", IR_DIV, 1'b0, 16'h0000, 16'h0000, F_Zhighout | F_HIin | F_Run, 5'd0);

    fetch_rows("neg", IR_NEG, 1'b0);
    row("neg T3", IR_NEG, 1'b0, 16'h0000, 16'h4000, F_ALU, 5'b10001);
    row("neg T4", IR_NEG, 1'b0, 16'h8000, 16'h0000, F_Zlowout | F_Run, 5'd0);

    fetch_rows("nop", IR_NOP, 1'b0);
    row("nop T3", IR_NOP, 1'b0, 16'h0, 16'h0, F_Run, 5'd0);

    fetch_rows("ill F8", IR_ILL1, 1'b0);
    row("ill F8 T3", IR_ILL1, 1'b0, 16'h0, 16'h0, F_Run | F_ill, 5'd0);

    fetch_rows("ill 60", IR_ILL2, 1'b0);
    row("ill 60 T3", IR_ILL2, 1'b0, 16'h0, 16'h0, F_Run | F_ill, 5'd0);

    fetch_rows("add stop", IR_ADD, 1'b0);
    row("add stop T3", IR_ADD, 1'b0, 16'h0000, 16'h0002, F_Yin | F_Run, 5'd0);
    row("add stop T4", IR_ADD, 1'b0, 16'h0000, 16'h0004, F_ALU, 5'd0);
    row("add stop T5", IR_ADD, 1'b1, 16'h0008, 16'h0000, F_Zlowout | F_Run, 5'd0);
    row("stop halt 0", IR_ADD, 1'b0, 16'h0, 16'h0, 20'h0, 5'd0);
    row("stop halt 1", IR_MUL, 1'b1, 16'h0, 16'h0, 20'h0, 5'd0);
    row("stop halt 2", IR_NEG, 1'b0, 16'h0, 16'h0, 20'h0, 5'd0);

    @(negedge clk);
    #1 check("reset state", '0);
    clr = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      IR   = tbl[i].ir;
      Stop = tbl[i].stop;
      #1 check(tbl[i].name, pk(tbl[i].rin, tbl[i].rout, tbl[i].f, tbl[i].alu));
      @(negedge clk);
    end

    // Clear asserted mid-T4 of add: transfer aborted before Rin can fire.
    reset_to_t0(IR_ADD);
    repeat (4) @(negedge clk);
    #1 check("abort pre T4", pk(16'h0, 16'h0004, F_ALU, 5'd0));
    #2 clr = 1'b0;
    #1 check("abort async clr", '0);
    @(negedge clk);
    #1 check("abort held in RST", '0);
    clr = 1'b1;
    #1 check("abort RST after release", '0);
    @(negedge clk);
    #1 check("abort restart T0", pk(16'h0, 16'h0, F_T0, 5'd0));
    @(negedge clk);
    #1 check("abort restart T1", pk(16'h0, 16'h0, F_T1, 5'd0));

    // Halt instruction: parks with everything low until clear.
    reset_to_t0(IR_HALT);
    #1 check("halt T0", pk(16'h0, 16'h0, F_T0, 5'd0));
    repeat (3) @(negedge clk);
    #1 check("halt T3", pk(16'h0, 16'h0, F_Run, 5'd0));
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      IR   = (k % 2 == 0) ? IR_ADD : IR_ILL1;
      Stop = k[0];
      #1 check($sformatf("halt hold %0d", k), '0);
    end
    reset_to_t0(IR_NOP);
    #1 check("halt exit via clr", pk(16'h0, 16'h0, F_T0, 5'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
